// File: rtl/processor_mc_pkg.sv
// Shared encodings for the multi-cycle 18-bit core: opcodes, branch
// conditions, register-register ALU operations and controller states.
package processor_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADDI = 4'd0,
        OP_LDI  = 4'd1,
        OP_LUI  = 4'd2,
        OP_LD   = 4'd3,
        OP_ST   = 4'd4,
        OP_BR   = 4'd5,
        OP_CALL = 4'd6,
        OP_RET  = 4'd7,
        OP_ALU  = 4'd8,
        OP_HALT = 4'd9
    } opcode_e;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_EQ     = 3'd1,
        COND_NE     = 3'd2,
        COND_LT     = 3'd3,
        COND_GE     = 3'd4,
        COND_GT     = 3'd5,
        COND_LE     = 3'd6,
        COND_NEVER  = 3'd7
    } cond_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SHL1 = 3'd5,
        ALU_SHR1 = 3'd6,
        ALU_SAR1 = 3'd7
    } alu_op_e;

    // Controller states kept as plain constants so older tools that poke
    // at the state register see stable numeric codes.
    localparam logic [2:0] ST_RESET = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

endpackage

// File: rtl/processor_mc_branch_cond.sv
// Signed branch-condition evaluation: decides whether a conditional
// branch is taken from the tested register value and the 3-bit condition.
module branch_cond
    import processor_mc_pkg::*;
#(
    parameter int WORD_SIZE = 18
) (
    input  logic [WORD_SIZE-1:0] rx,
    input  logic [2:0]           cond,
    output logic                 taken
);

    logic is_zero;
    logic is_neg;

    assign is_zero = (rx == '0);
    assign is_neg  = rx[WORD_SIZE-1];

    // Map the condition code onto zero/sign flags of the two's-complement value.
    always_comb begin
        taken = 1'b0;
        case (cond_e'(cond))
            COND_ALWAYS: taken = 1'b1;
            COND_EQ:     taken = is_zero;
            COND_NE:     taken = !is_zero;
            COND_LT:     taken = is_neg;
            COND_GE:     taken = !is_neg;
            COND_GT:     taken = !is_neg && !is_zero;
            COND_LE:     taken = is_neg || is_zero;
            COND_NEVER:  taken = 1'b0;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/processor_mc.sv
// Multi-cycle 18-bit core: FETCH/EXEC/MEM controller with handshaked code
// and data ports, eight general registers, call/return via a link register.
module processor_mc
    import processor_mc_pkg::*;
#(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 code_req,
    output logic [ADDR_SIZE-1:0] code_addr,
    input  logic [17:0]          code_word,
    input  logic                 code_valid,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic                 halted,
    output logic                 illegal
);

    logic [2:0]           state_q, state_d;
    logic [ADDR_SIZE-1:0] ip_q, ip_d, lr_q, lr_d;
    logic [17:0]          ir_q, ir_d;
    logic                 halted_q, halted_d, illegal_q, illegal_d;
    logic [WORD_SIZE-1:0] rf_q [8];
    logic [WORD_SIZE-1:0] rf_d [8];

    logic                 rf_we;
    logic [2:0]           rf_waddr;
    logic [WORD_SIZE-1:0] rf_wdata;

    logic [3:0]           op;
    logic [2:0]           rx_idx, ry_idx;
    logic [WORD_SIZE-1:0] rx_val, ry_val, imm8_w, imm11_w, eff_addr, alu_res;
    logic [ADDR_SIZE-1:0] imm8_a, imm11_a, ip_inc;
    logic                 br_taken;

    assign op       = ir_q[17:14];
    assign rx_idx   = ir_q[13:11];
    assign ry_idx   = ir_q[10:8];
    assign imm8_w   = {{(WORD_SIZE-8){ir_q[7]}}, ir_q[7:0]};
    assign imm11_w  = {{(WORD_SIZE-11){ir_q[10]}}, ir_q[10:0]};
    assign imm8_a   = {{(ADDR_SIZE-8){ir_q[7]}}, ir_q[7:0]};
    assign imm11_a  = {{(ADDR_SIZE-11){ir_q[10]}}, ir_q[10:0]};
    assign rx_val   = rf_q[rx_idx];
    assign ry_val   = rf_q[ry_idx];
    assign eff_addr = ry_val + imm8_w;
    assign ip_inc   = ip_q + ADDR_SIZE'(1);

    branch_cond #(.WORD_SIZE(WORD_SIZE)) u_branch_cond (
        .rx    (rx_val),
        .cond  (ir_q[10:8]),
        .taken (br_taken)
    );

    // Register-register ALU; shifts operate on rx only.
    always_comb begin
        alu_res = rx_val;
        case (alu_op_e'(ir_q[7:5]))
            ALU_ADD:  alu_res = rx_val + ry_val;
            ALU_SUB:  alu_res = rx_val - ry_val;
            ALU_AND:  alu_res = rx_val & ry_val;
            ALU_OR:   alu_res = rx_val | ry_val;
            ALU_XOR:  alu_res = rx_val ^ ry_val;
            ALU_SHL1: alu_res = {rx_val[WORD_SIZE-2:0], 1'b0};
            ALU_SHR1: alu_res = {1'b0, rx_val[WORD_SIZE-1:1]};
            ALU_SAR1: alu_res = {rx_val[WORD_SIZE-1], rx_val[WORD_SIZE-1:1]};
            default:  alu_res = rx_val;
        endcase
    end

    // Controller: sequences fetch/execute/memory and computes architectural updates.
    always_comb begin
        state_d   = state_q;
        ip_d      = ip_q;
        lr_d      = lr_q;
        ir_d      = ir_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        rf_waddr  = rx_idx;
        rf_wdata  = alu_res;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                if (code_valid) begin
                    ir_d    = code_word;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                ip_d    = ip_inc;
                case (op)
                    OP_ADDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = ry_val + imm8_w;
                    end
                    OP_LDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm11_w;
                    end
                    OP_LUI: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm11_w << 7;
                    end
                    OP_LD, OP_ST: begin
                        state_d = ST_MEM;
                        ip_d    = ip_q;
                    end
                    OP_BR: begin
                        if (br_taken) ip_d = ip_q + imm8_a;
                    end
                    OP_CALL: begin
                        lr_d = ip_inc;
                        ip_d = ip_q + imm11_a;
                    end
                    OP_RET: ip_d = lr_q;
                    OP_ALU: rf_we = 1'b1;
                    default: begin
                        state_d   = ST_HALT;
                        ip_d      = ip_q;
                        halted_d  = 1'b1;
                        illegal_d = (op != OP_HALT);
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    rf_we    = (op == OP_LD);
                    rf_wdata = mem_rdata;
                    ip_d     = ip_inc;
                    state_d  = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Single write port into the register file.
    always_comb begin
        rf_d = rf_q;
        if (rf_we) rf_d[rf_waddr] = rf_wdata;
    end

    // Architectural state; reset restarts fetching at address 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ip_q      <= '0;
            lr_q      <= '0;
            ir_q      <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ip_q      <= ip_d;
            lr_q      <= lr_d;
            ir_q      <= ir_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            rf_q      <= rf_d;
        end
    end

    assign code_req  = (state_q == ST_FETCH) && !reset;
    assign code_addr = ip_q;
    assign mem_req   = (state_q == ST_MEM);
    assign mem_we    = mem_req && (op == OP_ST);
    assign mem_addr  = eff_addr[ADDR_SIZE-1:0];
    assign mem_wdata = rx_val;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_processor_mc.sv
// Bench for processor_mc: ROM/RAM responders with wait states, and
// scoreboards of expected fetch addresses and data transactions.
module tb_processor_mc;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        code_req;
    logic [17:0] code_addr;
    logic [17:0] code_word = '0;
    logic        code_valid = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [17:0] mem_wdata;
    logic [17:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        halted;
    logic        illegal;

    typedef struct {
        logic        we;
        logic [17:0] addr;
        logic [17:0] wdata;
        int          delay;
    } mem_txn_t;

    mem_txn_t    mem_exp[$];
    logic [17:0] fetch_exp[$];
    logic [17:0] rom [256];
    logic [17:0] ram [256];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    processor_mc #(.ADDR_SIZE(18), .WORD_SIZE(18)) dut (
        .clock      (clock),
        .reset      (reset),
        .code_req   (code_req),
        .code_addr  (code_addr),
        .code_word  (code_word),
        .code_valid (code_valid),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .halted     (halted),
        .illegal    (illegal)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input int cycles);
        @(posedge clock);
        #1;
        reset = rst;
        repeat (cycles) @(negedge clock);
    endtask

    function automatic logic [17:0] enc(input int op, input int rx, input int ry, input logic [7:0] imm);
        return {op[3:0], rx[2:0], ry[2:0], imm};
    endfunction

    function automatic logic [17:0] enc11(input int op, input int rx, input logic [10:0] imm);
        return {op[3:0], rx[2:0], imm};
    endfunction

    function automatic void pushMem(input logic we, input logic [17:0] addr, input logic [17:0] wdata, input int delay);
        mem_txn_t t;
        t.we = we;
        t.addr = addr;
        t.wdata = wdata;
        t.delay = delay;
        mem_exp.push_back(t);
    endfunction

    // Code ROM: one wait state on odd addresses; junk valid pulses while not requested.
    int          code_cycles = 0;
    logic [17:0] code_addr_first = '0;
    always @(negedge clock) begin
        if (code_req) begin
            if (code_cycles == 0) code_addr_first = code_addr;
            else checkOutput("code_addr_stable", code_addr, code_addr_first);
            if (code_cycles >= int'(code_addr[0])) begin
                code_valid = 1'b1;
                code_word = rom[code_addr[7:0]];
                code_cycles = 0;
                checkOutput("fetch_expected", fetch_exp.size() > 0, 1);
                if (fetch_exp.size() > 0) checkOutput("fetch_addr", code_addr, fetch_exp.pop_front());
            end else begin
                code_valid = 1'b0;
                code_cycles++;
            end
        end else begin
            code_valid = 1'b1;
            code_word = 18'h3FFFF;
            code_cycles = 0;
        end
    end

    // Data RAM: per-transaction wait states taken from the scoreboard entry.
    int          mem_cycles = 0;
    logic [17:0] mem_addr_first = '0;
    bit          mem_done_prev = 1'b0;
    mem_txn_t    txn;
    always @(negedge clock) begin
        if (mem_done_prev) begin
            checkOutput("mem_req_drop", mem_req, 0);
            mem_done_prev = 1'b0;
        end
        if (!mem_req) begin
            checkOutput("mem_we_idle", mem_we, 0);
            mem_ready = 1'b0;
            mem_cycles = 0;
        end else begin
            if (mem_cycles == 0) begin
                mem_addr_first = mem_addr;
                checkOutput("mem_expected", mem_exp.size() > 0, 1);
            end else begin
                checkOutput("mem_addr_stable", mem_addr, mem_addr_first);
            end
            if (mem_exp.size() == 0) begin
                mem_ready = 1'b1;
                mem_cycles = 0;
            end else if (mem_cycles >= mem_exp[0].delay) begin
                txn = mem_exp.pop_front();
                checkOutput("mem_we", mem_we, txn.we);
                checkOutput("mem_addr", mem_addr, txn.addr);
                if (txn.we) begin
                    checkOutput("mem_wdata", mem_wdata, txn.wdata);
                    ram[mem_addr[7:0]] = mem_wdata;
                end else begin
                    mem_rdata = ram[mem_addr[7:0]];
                end
                mem_ready = 1'b1;
                mem_cycles = 0;
                mem_done_prev = 1'b1;
            end else begin
                mem_ready = 1'b0;
                mem_cycles++;
            end
        end
    end

    // Hard stop in case the core wedges somewhere the bounded waits miss.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed program runs.
    initial begin
        logic [17:0] halt_w;
        halt_w = enc11(9, 0, 11'h0);
        for (int i = 0; i < 256; i++) begin
            rom[i] = halt_w;
            ram[i] = '0;
        end
        ram[8'h20] = 18'h01234;

        rom[8'h00] = enc11(1, 1, 11'd5);
        rom[8'h01] = enc(0, 2, 1, 8'hFD);
        rom[8'h02] = enc(4, 2, 0, 8'h10);
        rom[8'h03] = enc(3, 3, 0, 8'h10);
        rom[8'h04] = enc(4, 3, 0, 8'h11);
        rom[8'h05] = enc(3, 3, 0, 8'h20);
        rom[8'h06] = enc(4, 3, 0, 8'h21);
        rom[8'h07] = enc11(1, 4, 11'h7FF);
        rom[8'h08] = enc(5, 4, 4, 8'h40);
        rom[8'h09] = enc(5, 0, 0, 8'h03);
        rom[8'h0A] = enc(4, 4, 0, 8'h30);
        rom[8'h0B] = enc(5, 0, 0, 8'h02);
        rom[8'h0C] = enc(5, 4, 3, 8'hFE);
        rom[8'h0D] = enc(5, 0, 0, 8'h13);
        rom[8'h20] = enc11(6, 0, 11'h040);
        rom[8'h60] = enc11(7, 0, 11'h0);
        rom[8'h21] = enc11(1, 6, 11'd1);
        rom[8'h22] = enc(8, 5, 6, 8'h20);
        rom[8'h23] = enc(4, 5, 0, 8'h31);
        rom[8'h24] = enc11(2, 7, 11'h400);
        rom[8'h25] = enc(8, 7, 0, 8'hE0);
        rom[8'h26] = enc(4, 7, 0, 8'h32);
        rom[8'h27] = enc(8, 7, 4, 8'h80);
        rom[8'h28] = enc(8, 4, 0, 8'hC0);
        rom[8'h29] = enc(4, 7, 0, 8'h33);
        rom[8'h2A] = enc(4, 4, 0, 8'h34);
        rom[8'h2B] = enc11(12, 0, 11'h0);

        for (int a = 0; a <= 9; a++) fetch_exp.push_back(18'(a));
        fetch_exp.push_back(18'h0C);
        fetch_exp.push_back(18'h0A);
        fetch_exp.push_back(18'h0B);
        fetch_exp.push_back(18'h0D);
        fetch_exp.push_back(18'h20);
        fetch_exp.push_back(18'h60);
        for (int a = 8'h21; a <= 8'h2B; a++) fetch_exp.push_back(18'(a));

        pushMem(1'b1, 18'h10, 18'h00002, 0);
        pushMem(1'b0, 18'h10, 18'h00000, 0);
        pushMem(1'b1, 18'h11, 18'h00002, 0);
        pushMem(1'b0, 18'h20, 18'h00000, 3);
        pushMem(1'b1, 18'h21, 18'h01234, 0);
        pushMem(1'b1, 18'h30, 18'h3FFFF, 1);
        pushMem(1'b1, 18'h31, 18'h3FFFF, 0);
        pushMem(1'b1, 18'h32, 18'h30000, 2);
        pushMem(1'b1, 18'h33, 18'h0FFFF, 0);
        pushMem(1'b1, 18'h34, 18'h1FFFF, 0);

        applyStimulus(1'b1, 3);
        checkOutput("rst_code_req", code_req, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_illegal", illegal, 0);

        applyStimulus(1'b0, 0);
        for (int i = 0; i < 3000 && halted !== 1'b1; i++) @(negedge clock);
        checkOutput("progA_halted", halted, 1);
        checkOutput("progA_illegal", illegal, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("halt_no_fetch", code_req, 0);
            checkOutput("halt_sticky", halted, 1);
        end
        checkOutput("progA_mem_left", mem_exp.size(), 0);
        checkOutput("progA_fetch_left", fetch_exp.size(), 0);

        applyStimulus(1'b1, 2);
        checkOutput("rst2_halted", halted, 0);
        checkOutput("rst2_illegal", illegal, 0);
        checkOutput("rst2_code_req", code_req, 0);
        for (int i = 0; i < 256; i++) rom[i] = halt_w;
        rom[0] = enc(3, 1, 0, 8'h10);
        fetch_exp.push_back(18'h0);
        pushMem(1'b0, 18'h10, 18'h0, 10);

        applyStimulus(1'b0, 0);
        for (int i = 0; i < 50 && mem_req !== 1'b1; i++) @(negedge clock);
        checkOutput("progB_mem_req", mem_req, 1);
        repeat (2) @(negedge clock);
        applyStimulus(1'b1, 2);
        checkOutput("abort_mem_req", mem_req, 0);
        checkOutput("abort_code_req", code_req, 0);
        mem_exp.delete();

        rom[0] = halt_w;
        fetch_exp.push_back(18'h0);
        applyStimulus(1'b0, 2);
        checkOutput("halt_not_yet", halted, 0);
        @(negedge clock);
        checkOutput("halt_timing", halted, 1);
        checkOutput("halt_legal", illegal, 0);
        checkOutput("progB_fetch_left", fetch_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
